instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Packs decoded instruction fields back into 32-bit instruction words, the reverse of the field decoder. It is used by the program loader and self-test harness to build instruction-memory images. Field sets arrive over a valid/ready handshake and are checked for a supported format (R-format opcode 0, I-format opcode 9). Encoded words are buffered in a small FIFO, tagged with a byte address, and drained to the instruction-memory write port over a second valid/ready handshake.

Parameters:
DEPTH, 4, output FIFO entries; power of two, at least 2.
ADDR_W, 10, width of the byte address.
BASE_ADDR, 0, byte address of the first word of each program.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  asynchronous reset, active-low.
start  input  1  one-cycle pulse; begins a program (honoured only in IDLE).
in_valid  input  1  field set valid.
in_ready  output  1  encoder can accept a field set.
in_last  input  1  qualifies the final field set of a program.
opcode  input  6  instruction opcode.
rs  input  5  source register.
rt  input  5  target register.
rd  input  5  destination register (R-format only).
shift_amt  input  5  shift amount (R-format only).
func  input  6  function code (R-format only).
immediate  input  16  immediate value (I-format only).
out_valid  output  1  encoded word available.
out_ready  input  1  memory writer accepts the word.
out_instr  output  32  encoded word.
out_addr  output  ADDR_W  byte address of out_instr.
word_cnt  output  ADDR_W  number of words pushed in the current program.
err  output  1  one-cycle pulse when a field set is rejected.
err_cnt  output  8  rejected field sets; saturates at 255.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle pulse when a program completes.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; FIFO empty.
  - All outputs 0, including in_ready, out_valid, out_instr, out_addr, word_cnt, err_cnt, done.
  - Reset asserted mid-program discards FIFO contents; no done pulse is produced.
- FSM has three states: IDLE, RUN, DRAIN (plus PAD when the macro is enabled).
  - IDLE: start moves to RUN. The same edge clears word_cnt and err_cnt and loads the address counter with BASE_ADDR.
  - RUN: field sets are accepted. An accepted field set with in_last=1 moves to DRAIN.
  - DRAIN: when the FIFO is empty, pulse done for one cycle and return to IDLE.
  - start is ignored outside IDLE.
- in_ready = (state==RUN) and FIFO not full. There is no full-bypass; a push never happens while full.
- Encoding on accept (in_valid and in_ready):
  - opcode 0 -> {6'd0, rs, rt, rd, shift_amt, func}.
  - opcode 9 -> {6'd9, rs, rt, immediate}.
  - Any other opcode: nothing is pushed; err pulses on the next cycle; err_cnt increments (saturating at 255); the address is not advanced. in_last on a rejected set still ends the program.
- A push stores {word, address}. After each push: address += 4, wrapping modulo 2^ADDR_W; word_cnt += 1.
- FIFO:
  - out_valid = not empty; out_instr and out_addr show the head entry.
  - Pop occurs when out_valid and out_ready are both high.
  - A simultaneous push and pop leaves the occupancy unchanged.
  - Latency: a word accepted on cycle N into an empty FIFO is visible at the outputs on cycle N+1.
  - out_instr and out_addr hold stable while out_valid=1 and out_ready=0.

Optional Feature:
Macro: ENC_NOP_PAD_EN.
- Defined: after in_last is accepted, if word_cnt is not a multiple of 4, the FSM enters PAD.
  - In PAD, in_ready=0 and one NOP (32'h00000000) is pushed per cycle whenever the FIFO is not full.
  - Each NOP gets the next address and increments word_cnt.
  - PAD ends when word_cnt is a multiple of 4, then moves to DRAIN.
- Undefined: no PAD state; in_last goes straight to DRAIN; images may be any length.

Test Plan:
- R-format encode: start; opcode=0, rs=1, rt=2, rd=3, shift_amt=0, func=6'h20, in_last=1, out_ready=1 -> out_instr=32'h00221820, out_addr=0, then done pulses and word_cnt=1.
- I-format encode: opcode=9, rs=1, rt=2, immediate=16'h0005 sent after one R word -> out_instr=32'h24220005 at out_addr=4.
- Reject: opcode=6'h23 sent between two valid words -> err pulses once, err_cnt=1, valid words land at addresses 0 and 4 with no gap.
- Backpressure: out_ready=0 with 6 field sets offered (DEPTH=4) -> in_ready drops after 4 accepts and out_instr stays stable; releasing out_ready drains all 6 words in order at addresses 0..20.
- Reset mid-program: rst_n pulled low with 3 words buffered -> out_valid=0 and busy=0 immediately with no done pulse; a new start restarts at address 0.
- ENC_NOP_PAD_EN: a 5-word program -> 3 NOPs appended at addresses 20, 24, 28; word_cnt=8; done pulses after the last pop.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs R/I-format field sets into 32-bit words and queues {word, byte address}
// for the instruction-memory writer. Define ENC_NOP_PAD_EN to pad each program to a 4-word multiple.
module instr_encoder #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [5:0]        opcode,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shift_amt,
   input  logic [5:0]        func,
   input  logic [15:0]       immediate,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic [ADDR_W-1:0] word_cnt,
   output logic              err,
   output logic [7:0]        err_cnt,
   output logic              busy,
   output logic              done
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [5:0] OP_R = 6'd0;
   localparam logic [5:0] OP_I = 6'd9;

`ifdef ENC_NOP_PAD_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, PAD = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
`endif

   state_t            state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic              err_q, err_d;
   logic [31:0]       mem_word_q [DEPTH];
   logic [ADDR_W-1:0] mem_addr_q [DEPTH];

   logic        empty, full, start_go, accept, fmt_ok, reject, pad_push, push, pop;
   logic [31:0] enc_word, push_word;

   // Handshakes: a field set transfers on a cycle with in_valid && in_ready, a word leaves
   // on a cycle with out_valid && out_ready; neither ready depends on its own valid.
   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign start_go  = (state_q == IDLE) && start;
   assign accept    = in_valid && in_ready;
   assign fmt_ok    = (opcode == OP_R) || (opcode == OP_I);
   assign reject    = accept && !fmt_ok;
   assign enc_word  = (opcode == OP_R) ? {opcode, rs, rt, rd, shift_amt, func}
                                       : {opcode, rs, rt, immediate};
   assign push_word = pad_push ? 32'h0000_0000 : enc_word;
   assign push      = (accept && fmt_ok) || pad_push;
   assign pop       = !empty && out_ready;

   assign out_valid = !empty;
   assign out_instr = empty ? 32'h0000_0000 : mem_word_q[rd_ptr_q];
   assign out_addr  = empty ? '0 : mem_addr_q[rd_ptr_q];
   assign word_cnt  = word_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign err       = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            if (accept && in_last) begin
`ifdef ENC_NOP_PAD_EN
               state_d = (word_cnt_d[1:0] != 2'b00) ? PAD : DRAIN;
`else
               state_d = DRAIN;
`endif
            end
         end
`ifdef ENC_NOP_PAD_EN
         PAD: if (word_cnt_q[1:0] == 2'b00) state_d = DRAIN;
`endif
         DRAIN: if (empty) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      done     = 1'b0;
      pad_push = 1'b0;
      busy     = (state_q != IDLE);
      case (state_q)
         RUN:   in_ready = !full;
         DRAIN: done = empty;
`ifdef ENC_NOP_PAD_EN
         PAD:   pad_push = (word_cnt_q[1:0] != 2'b00) && !full;
`endif
         default: ;
      endcase
   end

   // Rejected field sets leave the address untouched so valid words stay contiguous.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      addr_d     = addr_q;
      word_cnt_d = word_cnt_q;
      err_cnt_d  = err_cnt_q;
      err_d      = reject;
      count_d    = count_q + CW'(push) - CW'(pop);
      if (push) begin
         wr_ptr_d   = wr_ptr_q + 1'b1;
         addr_d     = addr_q + ADDR_W'(4);
         word_cnt_d = word_cnt_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (reject && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      if (start_go) begin
         addr_d     = ADDR_W'(BASE_ADDR);
         word_cnt_d = '0;
         err_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         addr_q     <= '0;
         word_cnt_q <= '0;
         err_cnt_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         word_cnt_q <= word_cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_q      <= err_d;
      end
   end

   // Storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_word_q[wr_ptr_q] <= push_word;
         mem_addr_q[wr_ptr_q] <= addr_q;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized field sets against an arithmetic encoding model
// with an expected {word, address} queue.
module tb_instr_encoder;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 10;
   localparam int EW     = 32 + ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_last = 1'b0;
   logic              out_ready = 1'b0;
   logic [5:0]        opcode = 6'd0;
   logic [4:0]        rs = 5'd0, rt = 5'd0, rd = 5'd0, shift_amt = 5'd0;
   logic [5:0]        func = 6'd0;
   logic [15:0]       immediate = 16'd0;
   logic              in_ready, out_valid, err, busy, done;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr, word_cnt;
   logic [7:0]        err_cnt;

   int                tests = 0;
   int                fails = 0;
   logic [EW-1:0]     exp_q[$];
   int                m_cnt = 0;
   int                m_rej = 0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic              ready_rand = 1'b0;
   logic              ready_force = 1'b0;

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shift_amt(shift_amt),
      .func(func), .immediate(immediate), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .word_cnt(word_cnt), .err(err),
      .err_cnt(err_cnt), .busy(busy), .done(done)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      tests++;
      assert (got === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
      end
   endtask

   // Instruction word from field values using plain positional arithmetic.
   function automatic logic [31:0] model_word(input int op, input int a, input int b,
                                               input int c, input int d, input int fn,
                                               input int imm);
      if (op == 0) return 32'(a * (2 ** 21) + b * (2 ** 16) + c * (2 ** 11) + d * (2 ** 6) + fn);
      return 32'(9 * (2 ** 26) + a * (2 ** 21) + b * (2 ** 16) + imm);
   endfunction

   // out_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   // scoreboard: the FIFO head must always match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL unexpected_word: observed %0h expected none", {out_instr, out_addr});
         end else begin
            chk("head", 64'({out_instr, out_addr}), 64'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // driver tasks (called at posedge + 1)
   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      m_cnt  = 0;
      m_rej  = 0;
      m_addr = '0;
      chk("start_busy", 64'(busy), 64'(1));
      chk("start_word_cnt", 64'(word_cnt), 64'(0));
      chk("start_err_cnt", 64'(err_cnt), 64'(0));
   endtask

   task automatic send_fs(input int op, input int a, input int b, input int c, input int d,
                          input int fn, input int imm, input int last);
      int guard = 0;
      opcode = 6'(op); rs = 5'(a); rt = 5'(b); rd = 5'(c); shift_amt = 5'(d);
      func = 6'(fn); immediate = 16'(imm); in_last = (last != 0); in_valid = 1'b1;
      @(negedge clk);
      while (in_ready !== 1'b1 && guard < 300) begin
         guard++;
         @(negedge clk);
      end
      if (guard >= 300) begin
         tests++;
         fails++;
         $error("FAIL accept_timeout: observed in_ready=%b expected 1", in_ready);
         in_valid = 1'b0;
         in_last  = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (op == 0 || op == 9) begin
         exp_q.push_back({model_word(op, a, b, c, d, fn, imm), m_addr});
         m_addr = m_addr + ADDR_W'(4);
         m_cnt++;
         chk("err_quiet", 64'(err), 64'(0));
      end else begin
         m_rej++;
         chk("err_pulse", 64'(err), 64'(1));
      end
`ifdef ENC_NOP_PAD_EN
      if (last != 0) begin
         while (m_cnt % 4 != 0) begin
            exp_q.push_back({32'h0000_0000, m_addr});
            m_addr = m_addr + ADDR_W'(4);
            m_cnt++;
         end
      end
`endif
   endtask

   task automatic wait_done();
      int guard = 0;
      @(negedge clk);
      while (done !== 1'b1 && guard < 2000) begin
         guard++;
         @(negedge clk);
      end
      chk("done_seen", 64'(done), 64'(1));
      chk("drained", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
      chk("idle_busy", 64'(busy), 64'(0));
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("end_word_cnt", 64'(word_cnt), 64'(m_cnt));
      chk("end_err_cnt", 64'(err_cnt), 64'((m_rej > 255) ? 255 : m_rej));
   endtask

   task automatic bad_op(output int op);
      do op = int'($urandom_range(1, 63)); while (op == 9);
   endtask

   // stimulus
   initial begin
      int op, n;
      #2 rst_n = 1'b0;
      #20;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_instr", 64'(out_instr), 64'(0));
      chk("rst_out_addr", 64'(out_addr), 64'(0));
      chk("rst_word_cnt", 64'(word_cnt), 64'(0));
      chk("rst_err_cnt", 64'(err_cnt), 64'(0));
      chk("rst_busy_done_err", 64'({busy, done, err}), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      ready_force = 1'b1;
      @(posedge clk);
      #1;

      // R-format
      do_start();
      send_fs(0, 1, 2, 3, 0, 32, 0, 1);
      chk("r_word", 64'(out_instr), 64'(32'h0022_1820));
      chk("r_addr", 64'(out_addr), 64'(0));
      wait_done();

      // I-format after one R word
      do_start();
      send_fs(0, 4, 5, 6, 7, 8, 0, 0);
      send_fs(9, 1, 2, 0, 0, 0, 5, 1);
      chk("i_word", 64'(out_instr), 64'(32'h2422_0005));
      chk("i_addr", 64'(out_addr), 64'(4));
      wait_done();

      // reject between two valid words
      do_start();
      send_fs(0, 3, 3, 3, 3, 3, 0, 0);
      send_fs(35, 1, 1, 1, 1, 1, 1, 0);
      send_fs(9, 7, 8, 0, 0, 0, 16'hBEEF, 1);
      wait_done();

      // backpressure: 6 sets into a 4-deep FIFO
      ready_force = 1'b0;
      do_start();
      for (int i = 0; i < 4; i++) send_fs(0, i, i + 1, i + 2, i, 32 + i, 0, 0);
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      @(posedge clk);
      #1;
      ready_force = 1'b1;
      send_fs(9, 10, 11, 0, 0, 0, 16'h1234, 0);
      send_fs(0, 12, 13, 14, 15, 63, 0, 1);
      wait_done();

      // reset with 3 words buffered
      ready_force = 1'b0;
      do_start();
      for (int i = 0; i < 3; i++) send_fs(9, i, i, 0, 0, 0, 100 + i, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_done", 64'(done), 64'(0));
      chk("mid_rst_word_cnt", 64'(word_cnt), 64'(0));
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      ready_force = 1'b1;
      @(negedge clk);
      chk("post_rst_no_done", 64'(done), 64'(0));
      @(posedge clk);
      #1;
      do_start();
      send_fs(0, 9, 9, 9, 9, 9, 0, 1);
      wait_done();

      // start ignored mid-program
      do_start();
      send_fs(0, 1, 1, 1, 1, 1, 0, 0);
      send_fs(9, 2, 2, 0, 0, 0, 2, 0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("start_ignored_cnt", 64'(word_cnt), 64'(2));
      send_fs(0, 3, 3, 3, 3, 3, 0, 1);
      wait_done();

      // rejected set carrying in_last still ends the program
      do_start();
      send_fs(9, 5, 6, 0, 0, 0, 77, 0);
      send_fs(63, 0, 0, 0, 0, 0, 0, 1);
      wait_done();

      // randomized programs with random backpressure
      ready_rand = 1'b1;
      for (int p = 0; p < 8; p++) begin
         do_start();
         n = int'($urandom_range(1, 12));
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            case ($urandom_range(0, 19))
               0, 1, 2: bad_op(op);
               3, 4, 5, 6, 7: op = 9;
               default: op = 0;
            endcase
            send_fs(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)),
                    (i == n - 1) ? 1 : 0);
         end
         wait_done();
      end
      ready_rand = 1'b0;
      ready_force = 1'b1;

      // address wrap: 260 words cross 2^ADDR_W bytes
      do_start();
      for (int i = 0; i < 260; i++)
         send_fs(9, i % 32, (i / 32) % 32, 0, 0, 0, int'($urandom_range(0, 65535)),
                 (i == 259) ? 1 : 0);
      wait_done();

      // err_cnt saturation
      do_start();
      for (int i = 0; i < 259; i++) begin
         bad_op(op);
         send_fs(op, 0, 0, 0, 0, 0, 0, (i == 258) ? 1 : 0);
      end
      wait_done();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
